// File: rtl/io_pinmux_arb_pkg.sv
// Shared definitions for the pad-bank arbiter: FSM state encoding and turnaround counter width.
package io_pinmux_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StTurn = 2'd1,
    StOwn  = 2'd2
  } pinmux_state_e;

  // Wide enough for TURN_CYC-1 with TURN_CYC up to 15.
  localparam int unsigned TurnCntW = 4;

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchronizer bank for asynchronous pad inputs.
module io_sync2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/io_pinmux_arb.sv
// Round-robin, non-preemptive arbiter granting a shared tri-state pad bank to one requester,
// with a fixed all-released turnaround window between owners.
module io_pinmux_arb
  import io_pinmux_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned NPAD     = 8,
  parameter int unsigned TURN_CYC = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NREQ-1:0]           req_i,
  output logic [NREQ-1:0]           gnt_o,
  input  logic [NREQ*NPAD-1:0]      do_i,
  input  logic [NREQ*NPAD-1:0]      oe_i,
  output logic [NPAD-1:0]           pad_c2p_o,
  output logic [NPAD-1:0]           pad_c2p_en_o,
  input  logic [NPAD-1:0]           pad_p2c_i,
  output logic [NPAD-1:0]           di_o,
  output logic [$clog2(NREQ)-1:0]   owner_o,
  output logic                      busy_o
);

  localparam int unsigned OwnerW = $clog2(NREQ);
  localparam logic [TurnCntW-1:0] TurnLoad = TurnCntW'(TURN_CYC - 1);
  localparam logic [NREQ-1:0] OneHot = NREQ'(1);

  pinmux_state_e        state_q;
  logic [OwnerW-1:0]    owner_q;
  logic [OwnerW-1:0]    last_owner_q;
  logic [TurnCntW-1:0]  cnt_q;
  logic [NREQ-1:0]      gnt_q;

  logic                 rr_found;
  logic [OwnerW-1:0]    rr_winner;
  logic [OwnerW-1:0]    rr_idx;

  // Search starts one past the last owner; in OWN the owner's own bit is already low.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    rr_idx    = '0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      rr_idx = OwnerW'((int'(last_owner_q) + i) % int'(NREQ));
      if (!rr_found && req_i[rr_idx]) begin
        rr_found  = 1'b1;
        rr_winner = rr_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_owner_q <= OwnerW'(NREQ - 1);
      cnt_q        <= '0;
      gnt_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rr_found) begin
            state_q <= StTurn;
            owner_q <= rr_winner;
            cnt_q   <= TurnLoad;
          end
        end
        StTurn: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - TurnCntW'(1);
          end else if (req_i[owner_q]) begin
            state_q      <= StOwn;
            gnt_q        <= OneHot << owner_q;
            last_owner_q <= owner_q;
          end else begin
            state_q <= StIdle;
            owner_q <= '0;
          end
        end
        StOwn: begin
          if (!req_i[owner_q]) begin
            gnt_q <= '0;
            if (rr_found) begin
              state_q <= StTurn;
              owner_q <= rr_winner;
              cnt_q   <= TurnLoad;
            end else begin
              state_q <= StIdle;
              owner_q <= '0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          owner_q <= '0;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  // Pads follow the owner combinationally; reset clears state_q, so release is immediate.
  always_comb begin
    pad_c2p_o    = '0;
    pad_c2p_en_o = '0;
    if (state_q == StOwn) begin
      pad_c2p_o    = do_i[owner_q*NPAD +: NPAD];
      pad_c2p_en_o = oe_i[owner_q*NPAD +: NPAD];
    end
  end

  io_sync2 #(
    .Width (NPAD)
  ) u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (pad_p2c_i),
    .q_o     (di_o)
  );

  assign gnt_o   = gnt_q;
  assign owner_o = owner_q;
  assign busy_o  = (state_q != StIdle);

endmodule

// File: tb/tb_io_pinmux_arb.sv
// Self-checking bench for io_pinmux_arb: directed vector table, corner sequences, random vs model.
module tb_io_pinmux_arb;

  localparam int NREQ = 4;
  localparam int NPAD = 8;
  localparam int TC   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] do_w;
  logic [31:0] oe_w;
  logic [7:0]  pad;
  logic [3:0]  gnt;
  logic [7:0]  c2p;
  logic [7:0]  en;
  logic [7:0]  di;
  logic [1:0]  owner;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  io_pinmux_arb #(
    .NREQ     (NREQ),
    .NPAD     (NPAD),
    .TURN_CYC (TC)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_i        (req),
    .gnt_o        (gnt),
    .do_i         (do_w),
    .oe_i         (oe_w),
    .pad_c2p_o    (c2p),
    .pad_c2p_en_o (en),
    .pad_p2c_i    (pad),
    .di_o         (di),
    .owner_o      (owner),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int i = 1; i <= NREQ; i++) begin
      if (r[(last + i) % NREQ]) return (last + i) % NREQ;
    end
    return -1;
  endfunction

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] own;
    logic [7:0] en;
    logic [7:0] c2p;
  } vec_t;

  vec_t tbl[14];

  // Reference model state
  int m_own, m_pend, m_left, m_last, m_w;
  logic [7:0] m_s1, m_di;

  int zc, gap_bad, wait_cnt;
  int exp_order[5];

  initial begin
    rst_n = 1'b0;
    req   = '0;
    do_w  = 32'hDDCCBBAA;
    oe_w  = 32'h44332211;
    pad   = 8'hFF;

    tbl[0]  = '{4'b0001, 4'b0000, 1'b1, 2'd0, 8'h00, 8'h00};
    tbl[1]  = '{4'b0001, 4'b0000, 1'b1, 2'd0, 8'h00, 8'h00};
    tbl[2]  = '{4'b0001, 4'b0001, 1'b1, 2'd0, 8'h11, 8'hAA};
    tbl[3]  = '{4'b0011, 4'b0001, 1'b1, 2'd0, 8'h11, 8'hAA};
    tbl[4]  = '{4'b0010, 4'b0000, 1'b1, 2'd1, 8'h00, 8'h00};
    tbl[5]  = '{4'b0010, 4'b0000, 1'b1, 2'd1, 8'h00, 8'h00};
    tbl[6]  = '{4'b0010, 4'b0010, 1'b1, 2'd1, 8'h22, 8'hBB};
    tbl[7]  = '{4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, 8'h00};
    tbl[8]  = '{4'b0100, 4'b0000, 1'b1, 2'd2, 8'h00, 8'h00};
    tbl[9]  = '{4'b0000, 4'b0000, 1'b1, 2'd2, 8'h00, 8'h00};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, 8'h00};
    tbl[11] = '{4'b1111, 4'b0000, 1'b1, 2'd2, 8'h00, 8'h00};
    tbl[12] = '{4'b1111, 4'b0000, 1'b1, 2'd2, 8'h00, 8'h00};
    tbl[13] = '{4'b1111, 4'b0100, 1'b1, 2'd2, 8'h33, 8'hCC};
    exp_order = '{0, 1, 2, 3, 0};

    // Reset values while reset is held
    #12;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_en", 32'(en), 0);
    check("rst_c2p", 32'(c2p), 0);
    check("rst_di", 32'(di), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      req = tbl[i].req;
      tick();
      check($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      check($sformatf("tbl%0d_owner", i), 32'(owner), 32'(tbl[i].own));
      check($sformatf("tbl%0d_en", i), 32'(en), 32'(tbl[i].en));
      check($sformatf("tbl%0d_c2p", i), 32'(c2p), 32'(tbl[i].c2p));
    end

    // Asynchronous reset mid-OWN releases pads without a clock edge
    oe_w = '1;
    #1;
    check("own_en_ones", 32'(en), 32'hFF);
    rst_n = 1'b0;
    #1;
    check("arst_en", 32'(en), 0);
    check("arst_c2p", 32'(c2p), 0);
    check("arst_gnt", 32'(gnt), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_owner", 32'(owner), 0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // No preemption; handoff after exactly 1+TC cycles
    req = 4'b0100;
    repeat (3) tick();
    check("np_gnt2", 32'(gnt), 32'h4);
    req = 4'b0101;
    repeat (4) tick();
    check("np_hold", 32'(gnt), 32'h4);
    req = 4'b0001;
    wait_cnt = 0;
    do begin
      tick();
      wait_cnt++;
    end while (gnt != 4'b0001 && wait_cnt < 20);
    check("handoff_cycles", 32'(wait_cnt), 32'(1 + TC));
    check("handoff_gnt", 32'(gnt), 32'h1);

    // Full round-robin rotation with gaps
    req = '0;
    do_reset();
    req = '1;
    gap_bad = 0;
    for (int k = 0; k < 5; k++) begin
      zc = 0;
      do begin
        tick();
        if (gnt == 0) begin
          zc++;
          if (en != 0) gap_bad++;
        end
      end while (gnt == 0 && zc < 20);
      check($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(1) << exp_order[k]);
      check($sformatf("rr%0d_gap", k), 32'(zc), 32'(TC));
      req = '1;
      repeat (4) tick();
      req[exp_order[k]] = 1'b0;
    end
    check("gap_en_zero", 32'(gap_bad), 0);

    // Synchronizer latency
    req = '0;
    do_reset();
    pad = 8'h00;
    repeat (3) tick();
    pad = 8'hFF;
    tick();
    check("sync_edge1", 32'(di), 32'h00);
    tick();
    check("sync_edge2", 32'(di), 32'hFF);

    // Randomized run against the behavioural model
    req = '0;
    do_reset();
    m_own  = -1;
    m_pend = -1;
    m_left = 0;
    m_last = NREQ - 1;
    m_s1   = '0;
    m_di   = '0;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      end
      do_w = $urandom;
      oe_w = $urandom;
      if ($urandom_range(0, 3) == 0) pad = 8'($urandom);
      #1;
      check("rnd_gnt", 32'(gnt), (m_own >= 0) ? (32'(1) << m_own) : 0);
      check("rnd_busy", 32'(busy), 32'((m_own >= 0) || (m_pend >= 0)));
      check("rnd_owner", 32'(owner), (m_own >= 0) ? 32'(m_own) : (m_pend >= 0) ? 32'(m_pend) : 0);
      check("rnd_en", 32'(en), (m_own >= 0) ? 32'(oe_w[m_own*8 +: 8]) : 0);
      check("rnd_c2p", 32'(c2p), (m_own >= 0) ? 32'(do_w[m_own*8 +: 8]) : 0);
      check("rnd_di", 32'(di), 32'(m_di));
      // Advance the model by one clock edge
      m_di = m_s1;
      m_s1 = pad;
      if (m_pend >= 0) begin
        m_left--;
        if (m_left == 0) begin
          if (req[m_pend]) begin
            m_own  = m_pend;
            m_last = m_pend;
          end
          m_pend = -1;
        end
      end else if (m_own >= 0) begin
        if (!req[m_own]) begin
          m_own = -1;
          m_w   = rr_pick(req, m_last);
          if (m_w >= 0) begin
            m_pend = m_w;
            m_left = TC;
          end
        end
      end else begin
        m_w = rr_pick(req, m_last);
        if (m_w >= 0) begin
          m_pend = m_w;
          m_left = TC;
        end
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
